// File: rtl/frv_lsu_reqbuf_if.sv
// Request/bus/result signal bundle for frv_lsu_reqbuf.
// slave: the buffer; master: the memory stage, data bus and writeback side.
interface frv_lsu_reqbuf_if #(
  parameter int XLEN = 32
) ();
  logic            req_valid;
  logic            req_ready;
  logic            req_load;
  logic            req_store;
  logic [1:0]      req_size;
  logic            req_signed;
  logic [4:0]      req_tag;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;

  logic            dmem_req;
  logic            dmem_gnt;
  logic            dmem_wen;
  logic [3:0]      dmem_strb;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_recv;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_error;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [4:0]      rsp_tag;
  logic            rsp_load;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_error;
  logic            rsp_misalign;

  modport slave (
    input  req_valid, req_load, req_store, req_size, req_signed, req_tag, req_addr, req_wdata,
    output req_ready,
    output dmem_req, dmem_wen, dmem_strb, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_recv, dmem_rdata, dmem_error,
    output rsp_valid, rsp_tag, rsp_load, rsp_rdata, rsp_error, rsp_misalign,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_load, req_store, req_size, req_signed, req_tag, req_addr, req_wdata,
    input  req_ready,
    input  dmem_req, dmem_wen, dmem_strb, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_recv, dmem_rdata, dmem_error,
    input  rsp_valid, rsp_tag, rsp_load, rsp_rdata, rsp_error, rsp_misalign,
    output rsp_ready
  );
endinterface

// File: rtl/frv_lsu_reqbuf.sv
// LSU request buffer: issue register + DEPTH-deep in-order tracker; dmem_req at accept+1, rsp_valid at recv+1, req_ready low when busy/full.
// Option FRV_LSU_REQBUF_LEAK_CLEAR_EN: flush/leak_fence overwrite issue addr/wdata and all tracked rdata with leak_prng.
module frv_lsu_reqbuf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  input  logic                 flush,
  input  logic                 leak_fence,
  input  logic [XLEN-1:0]      leak_prng,
  input  logic                 hold_req,
  frv_lsu_reqbuf_if.slave      bus
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [4:0]      tag;
    logic            load;
    logic [1:0]      size;
    logic            sgn;
    logic [1:0]      off;
    logic            done;
    logic            error;
    logic            misalign;
    logic            killed;
    logic [XLEN-1:0] rdata;
  } ent_t;

  logic            issue_valid;
  logic            issue_load;
  logic            issue_store;
  logic            issue_sgn;
  logic            issue_mis;
  logic [1:0]      issue_size;
  logic [1:0]      issue_off;
  logic [4:0]      issue_tag;
  logic [3:0]      issue_strb;
  logic [XLEN-1:0] issue_addr;
  logic [XLEN-1:0] issue_wdata;

  ent_t            fifo_q [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     count;

  logic            not_full;
  logic            accept;
  logic            req_mis;
  logic [3:0]      req_strb;
  logic            push_gnt;
  logic            push_mis;
  logic            push;
  logic            pop;
  logic            head_live;
  logic            scrub;
  ent_t            head;
  ent_t            new_ent;
  ent_t            cmp_ent;
  logic            cmp_hit;
  logic            cmp_en;
  logic [AW-1:0]   cmp_idx;
  logic [AW-1:0]   scan_idx;
  logic [XLEN-1:0] cmp_rdata;

`ifdef FRV_LSU_REQBUF_LEAK_CLEAR_EN
  assign scrub = flush | leak_fence;
`else
  logic unused_leak;
  assign scrub       = 1'b0;
  assign unused_leak = leak_fence;
`endif

  function automatic logic [XLEN-1:0] fmt_load(input logic ld, input logic [1:0] size,
                                               input logic sgn, input logic [1:0] off,
                                               input logic [XLEN-1:0] d);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh = d >> {off, 3'b000};
    case (size)
      2'b00:   res = {{(XLEN-8){sgn & sh[7]}}, sh[7:0]};
      2'b01:   res = {{(XLEN-16){sgn & sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return ld ? res : '0;
  endfunction

  assign not_full      = count < DEPTH_C;
  assign bus.req_ready = !issue_valid && not_full;
  assign accept        = bus.req_valid && bus.req_ready;

  assign req_mis = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);

  always_comb begin
    case (bus.req_size)
      2'b00:   req_strb = 4'b0001;
      2'b01:   req_strb = 4'b0011;
      default: req_strb = 4'b1111;
    endcase
    req_strb = req_strb << bus.req_addr[1:0];
  end

  // Misaligned accesses bypass the bus and retire straight into the tracker.
  assign bus.dmem_req   = issue_valid && !issue_mis && !hold_req && not_full;
  assign bus.dmem_wen   = issue_store;
  assign bus.dmem_strb  = issue_strb;
  assign bus.dmem_addr  = {issue_addr[XLEN-1:2], 2'b00};
  assign bus.dmem_wdata = issue_wdata;

  assign push_gnt = bus.dmem_req && bus.dmem_gnt;
  assign push_mis = issue_valid && issue_mis && not_full;
  assign push     = push_gnt || push_mis;

  assign head      = fifo_q[rd_ptr];
  assign head_live = count != '0;
  assign bus.rsp_valid    = head_live && head.done && !head.killed;
  assign pop              = (bus.rsp_valid && bus.rsp_ready) || (head_live && head.done && head.killed);
  assign bus.rsp_tag      = head.tag;
  assign bus.rsp_load     = head.load;
  assign bus.rsp_rdata    = head.rdata;
  assign bus.rsp_error    = head.error;
  assign bus.rsp_misalign = head.misalign;

  always_comb begin
    new_ent          = '0;
    new_ent.tag      = issue_tag;
    new_ent.load     = issue_load;
    new_ent.size     = issue_size;
    new_ent.sgn      = issue_sgn;
    new_ent.off      = issue_off;
    new_ent.done     = issue_mis;
    new_ent.misalign = issue_mis;
    new_ent.killed   = flush;
    new_ent.rdata    = scrub ? leak_prng : '0;
  end

  // Responses are in order: the oldest not-yet-done entry owns dmem_recv.
  always_comb begin
    cmp_hit  = 1'b0;
    cmp_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr + AW'(i);
      if (!cmp_hit && ((AW+1)'(i) < count) && !fifo_q[scan_idx].done) begin
        cmp_hit = 1'b1;
        cmp_idx = scan_idx;
      end
    end
  end

  assign cmp_en    = bus.dmem_recv && cmp_hit;
  assign cmp_ent   = fifo_q[cmp_idx];
  assign cmp_rdata = bus.dmem_error ? '0 :
                     fmt_load(cmp_ent.load, cmp_ent.size, cmp_ent.sgn, cmp_ent.off, bus.dmem_rdata);

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      issue_valid <= 1'b0;
      issue_load  <= 1'b0;
      issue_store <= 1'b0;
      issue_sgn   <= 1'b0;
      issue_mis   <= 1'b0;
      issue_size  <= '0;
      issue_off   <= '0;
      issue_tag   <= '0;
      issue_strb  <= '0;
      issue_addr  <= '0;
      issue_wdata <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (flush) begin
        issue_valid <= 1'b0;
      end else if (accept) begin
        issue_valid <= 1'b1;
      end else if (push) begin
        issue_valid <= 1'b0;
      end

      if (accept && !flush) begin
        issue_load  <= bus.req_load;
        issue_store <= bus.req_store;
        issue_sgn   <= bus.req_signed;
        issue_mis   <= req_mis;
        issue_size  <= bus.req_size;
        issue_off   <= bus.req_addr[1:0];
        issue_tag   <= bus.req_tag;
        issue_strb  <= req_strb;
        issue_addr  <= bus.req_addr;
        issue_wdata <= bus.req_wdata << {bus.req_addr[1:0], 3'b000};
      end
      if (scrub) begin
        issue_addr  <= leak_prng;
        issue_wdata <= leak_prng;
      end

      for (int i = 0; i < DEPTH; i++) begin
        if (cmp_en && cmp_idx == AW'(i)) begin
          fifo_q[i].done  <= 1'b1;
          fifo_q[i].error <= bus.dmem_error;
          fifo_q[i].rdata <= cmp_rdata;
        end
        if (flush) begin
          fifo_q[i].killed <= 1'b1;
        end
        if (scrub) begin
          fifo_q[i].rdata <= leak_prng;
        end
      end

      if (push) begin
        fifo_q[wr_ptr] <= new_ent;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
